// File: rtl/alarm_sequencer_pkg.sv
// Shared definitions for the alarm sequencer: state encodings, the STATE width and the time-match helper.
// The display logic decodes STATE with the same encodings.
package alarm_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED = 3'd0,
        ST_ARMED    = 3'd1,
        ST_RINGING  = 3'd2,
        ST_SNOOZE   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // The alarm fires only on the tick that lands on second zero of the alarm minute.
    function automatic logic alarm_match(
        input logic       tick,
        input logic [4:0] cur_hour,
        input logic [4:0] alm_hour,
        input logic [5:0] cur_min,
        input logic [5:0] alm_min,
        input logic [5:0] cur_sec
    );
        return tick && (cur_hour == alm_hour) && (cur_min == alm_min) && (cur_sec == 6'd0);
    endfunction

endpackage

// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the time-keeping/keypad side (master) and the alarm sequencer (slave).
// The piezo controls and status come back on the same bundle.
interface alarm_sequencer_if;
    import alarm_sequencer_pkg::*;

    logic               SEC_TICK;
    logic               ALARM_ON;
    logic [4:0]         CUR_HOUR;
    logic [5:0]         CUR_MIN;
    logic [5:0]         CUR_SEC;
    logic [4:0]         ALM_HOUR;
    logic [5:0]         ALM_MIN;
    logic               KEY_STOP;
    logic               KEY_SNOOZE;
    logic               KEY_PRESS;
    logic               ALARM_ENABLE;
    logic               ALARM_DOING;
    logic [STATE_W-1:0] STATE;
    logic [1:0]         SNOOZE_LEFT;

    modport master (
        output SEC_TICK, ALARM_ON, CUR_HOUR, CUR_MIN, CUR_SEC, ALM_HOUR, ALM_MIN,
        output KEY_STOP, KEY_SNOOZE, KEY_PRESS,
        input  ALARM_ENABLE, ALARM_DOING, STATE, SNOOZE_LEFT
    );

    modport slave (
        input  SEC_TICK, ALARM_ON, CUR_HOUR, CUR_MIN, CUR_SEC, ALM_HOUR, ALM_MIN,
        input  KEY_STOP, KEY_SNOOZE, KEY_PRESS,
        output ALARM_ENABLE, ALARM_DOING, STATE, SNOOZE_LEFT
    );

endinterface

// File: rtl/alarm_sequencer_key_beep_timer.sv
// Key-click beep timer: a KEY_PRESS rising edge (when allowed) loads a cycle countdown.
// beep_active_next is the next-cycle beep state so the parent can register it with the alarm outputs.
module key_beep_timer
    import alarm_sequencer_pkg::*;
#(
    parameter int BEEP_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic key_press,
    input  logic allow,
    input  logic abort,
    output logic beep_active_next
);

    localparam int BW = $clog2(BEEP_CYCLES + 1);
    localparam logic [BW-1:0] BEEP_LOAD = BW'(BEEP_CYCLES);

    logic          key_prev_q, key_prev_d;
    logic [BW-1:0] beep_cnt_q, beep_cnt_d;

    always_comb begin
        key_prev_d = key_press;
        beep_cnt_d = beep_cnt_q;
        if (abort) begin
            beep_cnt_d = '0;
        end else if (key_press && !key_prev_q && allow) begin
            beep_cnt_d = BEEP_LOAD;
        end else if (beep_cnt_q != '0) begin
            beep_cnt_d = beep_cnt_q - BW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            key_prev_q <= 1'b0;
            beep_cnt_q <= '0;
        end else begin
            key_prev_q <= key_prev_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign beep_active_next = (beep_cnt_d != '0);

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: arms on ALARM_ON, rings on the time match, handles snooze/stop/timeout,
// and lends the piezo to the key-click beep whenever the alarm is not using it.
module alarm_sequencer
    import alarm_sequencer_pkg::*;
#(
    parameter int RING_TIMEOUT_SEC = 60,
    parameter int SNOOZE_SEC       = 300,
    parameter int MAX_SNOOZE       = 3,
    parameter int BEEP_CYCLES      = 50000
) (
    input  logic               CLK,
    input  logic               RESETN,
    alarm_sequencer_if.slave   io
);

    localparam int RW = $clog2(RING_TIMEOUT_SEC + 1);
    localparam int SW = $clog2(SNOOZE_SEC + 1);
    localparam logic [RW-1:0] RING_LIMIT = RW'(RING_TIMEOUT_SEC);
    localparam logic [SW-1:0] SNZ_LOAD   = SW'(SNOOZE_SEC);
    localparam logic [1:0]    SNZ_MAX    = 2'(MAX_SNOOZE);

    state_t        state_q, state_d;
    logic [RW-1:0] ring_timer_q, ring_timer_d;
    logic [SW-1:0] snz_timer_q, snz_timer_d;
    logic [1:0]    snooze_left_q, snooze_left_d;
    logic          stop_prev_q, stop_prev_d;
    logic          snooze_prev_q, snooze_prev_d;
    logic          piezo_q, piezo_d;

    logic stop_edge, snooze_edge, match;
    logic enter_ring, beep_allow, beep_next;

    always_comb begin
        stop_prev_d   = io.KEY_STOP;
        snooze_prev_d = io.KEY_SNOOZE;
        stop_edge     = io.KEY_STOP & ~stop_prev_q;
        snooze_edge   = io.KEY_SNOOZE & ~snooze_prev_q;
        match         = alarm_match(io.SEC_TICK, io.CUR_HOUR, io.ALM_HOUR,
                                    io.CUR_MIN, io.ALM_MIN, io.CUR_SEC);

        state_d       = state_q;
        ring_timer_d  = ring_timer_q;
        snz_timer_d   = snz_timer_q;
        snooze_left_d = snooze_left_q;

        // Dropping the arm switch beats every key and timer event in the same cycle.
        if (!io.ALARM_ON) begin
            state_d = ST_DISARMED;
        end else begin
            case (state_q)
                ST_DISARMED: state_d = ST_ARMED;
                ST_ARMED: begin
                    if (match) begin
                        state_d       = ST_RINGING;
                        ring_timer_d  = '0;
                        snooze_left_d = SNZ_MAX;
                    end
                end
                ST_RINGING: begin
                    if (stop_edge) begin
                        state_d = ST_DONE;
                    end else if (snooze_edge && snooze_left_q != 2'd0) begin
                        state_d       = ST_SNOOZE;
                        snooze_left_d = snooze_left_q - 2'd1;
                        snz_timer_d   = SNZ_LOAD;
                    end else if (io.SEC_TICK) begin
                        if (ring_timer_q != RING_LIMIT) begin
                            ring_timer_d = ring_timer_q + RW'(1);
                        end
                        if (ring_timer_d == RING_LIMIT) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (stop_edge) begin
                        state_d = ST_DONE;
                    end else if (io.SEC_TICK) begin
                        if (snz_timer_q <= SW'(1)) begin
                            snz_timer_d  = '0;
                            state_d      = ST_RINGING;
                            ring_timer_d = '0;
                        end else begin
                            snz_timer_d = snz_timer_q - SW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Waiting out the alarm minute prevents an immediate retrigger.
                    if (io.CUR_MIN != io.ALM_MIN) begin
                        state_d = ST_ARMED;
                    end
                end
                default: state_d = ST_DISARMED;
            endcase
        end

        enter_ring = (state_d == ST_RINGING) && (state_q != ST_RINGING);
        beep_allow = (state_q == ST_DISARMED) || (state_q == ST_ARMED) || (state_q == ST_DONE);
    end

    key_beep_timer #(
        .BEEP_CYCLES (BEEP_CYCLES)
    ) u_beep (
        .CLK              (CLK),
        .RESETN           (RESETN),
        .key_press        (io.KEY_PRESS),
        .allow            (beep_allow),
        .abort            (enter_ring),
        .beep_active_next (beep_next)
    );

    assign piezo_d = (state_d == ST_RINGING) | beep_next;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q       <= ST_DISARMED;
            ring_timer_q  <= '0;
            snz_timer_q   <= '0;
            snooze_left_q <= SNZ_MAX;
            stop_prev_q   <= 1'b0;
            snooze_prev_q <= 1'b0;
            piezo_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            ring_timer_q  <= ring_timer_d;
            snz_timer_q   <= snz_timer_d;
            snooze_left_q <= snooze_left_d;
            stop_prev_q   <= stop_prev_d;
            snooze_prev_q <= snooze_prev_d;
            piezo_q       <= piezo_d;
        end
    end

    assign io.ALARM_ENABLE = piezo_q;
    assign io.ALARM_DOING  = piezo_q;
    assign io.STATE        = state_q;
    assign io.SNOOZE_LEFT  = snooze_left_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with short timers: ring, snooze, stop, beep, disarm and reset scenarios.
module tb_alarm_sequencer;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   failures = 0;

    alarm_sequencer_if io ();

    alarm_sequencer #(
        .RING_TIMEOUT_SEC (4),
        .SNOOZE_SEC       (3),
        .MAX_SNOOZE       (2),
        .BEEP_CYCLES      (8)
    ) dut (
        .CLK    (clk),
        .RESETN (rstn),
        .io     (io.slave)
    );

    always #5 clk = ~clk;

    // {STATE, ALARM_ENABLE, ALARM_DOING, SNOOZE_LEFT}
    function automatic logic [6:0] obs();
        return {io.STATE, io.ALARM_ENABLE, io.ALARM_DOING, io.SNOOZE_LEFT};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        io.CUR_HOUR = h;
        io.CUR_MIN  = m;
        io.CUR_SEC  = s;
        io.SEC_TICK = 1'b1;
        cyc();
        io.SEC_TICK = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        rstn = 1'b0;
        io.ALARM_ON = 1'b0; io.SEC_TICK = 1'b0;
        io.KEY_STOP = 1'b0; io.KEY_SNOOZE = 1'b0; io.KEY_PRESS = 1'b0;
        io.CUR_HOUR = 5'd7; io.CUR_MIN = 6'd29; io.CUR_SEC = 6'd0;
        io.ALM_HOUR = 5'd7; io.ALM_MIN = 6'd30;
        cyc(); cyc();
        e = {3'd0, 2'b00, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL reset_state got=%b exp=%b", obs(), e); end
        rstn = 1'b1;
        cyc(); cyc();
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL disarmed_hold got=%b exp=%b", obs(), e); end
    endtask

    task automatic test_ring_timeout();
        logic [6:0] e;
        io.ALARM_ON = 1'b1;
        cyc();
        e = {3'd1, 2'b00, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL armed got=%b exp=%b", obs(), e); end
        do_tick(5'd7, 6'd29, 6'd59);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL no_early_ring got=%b exp=%b", obs(), e); end
        do_tick(5'd7, 6'd30, 6'd0);
        e = {3'd2, 2'b11, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL ring_start got=%b exp=%b", obs(), e); end
        for (int i = 1; i <= 3; i++) do_tick(5'd7, 6'd30, 6'(i));
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL ring_after3 got=%b exp=%b", obs(), e); end
        do_tick(5'd7, 6'd30, 6'd4);
        e = {3'd4, 2'b00, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL ring_timeout got=%b exp=%b", obs(), e); end
        io.CUR_MIN = 6'd31;
        cyc();
        e = {3'd1, 2'b00, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL done_to_armed got=%b exp=%b", obs(), e); end
    endtask

    task automatic test_snooze();
        logic [6:0] e;
        io.ALM_MIN = 6'd32;
        do_tick(5'd7, 6'd32, 6'd0);
        io.KEY_SNOOZE = 1'b1; cyc(); io.KEY_SNOOZE = 1'b0;
        e = {3'd3, 2'b00, 2'd1};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL snooze1 got=%b exp=%b", obs(), e); end
        do_tick(5'd7, 6'd32, 6'd1);
        do_tick(5'd7, 6'd32, 6'd2);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL snooze_hold got=%b exp=%b", obs(), e); end
        do_tick(5'd7, 6'd32, 6'd3);
        e = {3'd2, 2'b11, 2'd1};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL snooze_rering got=%b exp=%b", obs(), e); end
        io.KEY_SNOOZE = 1'b1; cyc(); io.KEY_SNOOZE = 1'b0;
        e = {3'd3, 2'b00, 2'd0};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL snooze2 got=%b exp=%b", obs(), e); end
        for (int i = 4; i <= 6; i++) do_tick(5'd7, 6'd32, 6'(i));
        io.KEY_SNOOZE = 1'b1; cyc(); io.KEY_SNOOZE = 1'b0;
        e = {3'd2, 2'b11, 2'd0};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL snooze3_ignored got=%b exp=%b", obs(), e); end
        io.KEY_STOP = 1'b1; cyc(); io.KEY_STOP = 1'b0;
        e = {3'd4, 2'b00, 2'd0};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL stop_ring got=%b exp=%b", obs(), e); end
    endtask

    task automatic test_stop_priority();
        logic [6:0] e;
        io.ALM_MIN = 6'd34;
        cyc();
        e = {3'd1, 2'b00, 2'd0};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL rearm got=%b exp=%b", obs(), e); end
        do_tick(5'd7, 6'd34, 6'd0);
        e = {3'd2, 2'b11, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL ring_reload got=%b exp=%b", obs(), e); end
        io.KEY_STOP = 1'b1; io.KEY_SNOOZE = 1'b1; cyc();
        io.KEY_STOP = 1'b0; io.KEY_SNOOZE = 1'b0;
        e = {3'd4, 2'b00, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL stop_beats_snooze got=%b exp=%b", obs(), e); end
        cyc();
        do_tick(5'd7, 6'd34, 6'd5);
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL done_hold got=%b exp=%b", obs(), e); end
        io.CUR_MIN = 6'd35;
        cyc();
        e = {3'd1, 2'b00, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL done_exit got=%b exp=%b", obs(), e); end
    endtask

    task automatic test_beep();
        logic [6:0] e;
        int hi;
        io.ALM_MIN = 6'd36;
        io.KEY_PRESS = 1'b1; cyc();
        e = {3'd1, 2'b11, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL beep_start got=%b exp=%b", obs(), e); end
        hi = 1;
        for (int i = 0; i < 11; i++) begin
            cyc();
            if (io.ALARM_ENABLE && io.ALARM_DOING) hi++;
        end
        checks++;
        if (hi !== 8) begin failures++; $display("FAIL beep_len got=%0d exp=8", hi); end
        e = {3'd1, 2'b00, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL beep_end got=%b exp=%b", obs(), e); end
        io.KEY_PRESS = 1'b0; cyc();
        io.KEY_PRESS = 1'b1; cyc(); io.KEY_PRESS = 1'b0;
        cyc(); cyc();
        do_tick(5'd7, 6'd36, 6'd0);
        e = {3'd2, 2'b11, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL beep_to_ring got=%b exp=%b", obs(), e); end
        io.KEY_PRESS = 1'b1; cyc(); io.KEY_PRESS = 1'b0;
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL key_in_ring got=%b exp=%b", obs(), e); end
        io.KEY_STOP = 1'b1; cyc(); io.KEY_STOP = 1'b0;
        e = {3'd4, 2'b00, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL beep_aborted got=%b exp=%b", obs(), e); end
        io.CUR_MIN = 6'd37;
        cyc();
    endtask

    task automatic test_disarm();
        logic [6:0] e;
        io.ALM_MIN = 6'd38;
        do_tick(5'd7, 6'd38, 6'd0);
        io.KEY_SNOOZE = 1'b1; cyc(); io.KEY_SNOOZE = 1'b0;
        do_tick(5'd7, 6'd38, 6'd1);
        do_tick(5'd7, 6'd38, 6'd2);
        io.ALARM_ON = 1'b0;
        do_tick(5'd7, 6'd38, 6'd3);
        e = {3'd0, 2'b00, 2'd1};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL disarm_in_snooze got=%b exp=%b", obs(), e); end
        for (int i = 4; i <= 7; i++) do_tick(5'd7, 6'd38, 6'(i));
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL no_rering got=%b exp=%b", obs(), e); end
        io.ALARM_ON = 1'b1; cyc();
        e = {3'd1, 2'b00, 2'd1};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL rearm_after_disarm got=%b exp=%b", obs(), e); end
    endtask

    task automatic test_reset_mid_ring();
        logic [6:0] e;
        io.ALM_MIN = 6'd40;
        do_tick(5'd7, 6'd40, 6'd0);
        io.KEY_SNOOZE = 1'b1; cyc(); io.KEY_SNOOZE = 1'b0;
        for (int i = 1; i <= 3; i++) do_tick(5'd7, 6'd40, 6'(i));
        e = {3'd2, 2'b11, 2'd1};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL pre_reset_ring got=%b exp=%b", obs(), e); end
        io.KEY_STOP = 1'b1; rstn = 1'b0; cyc(); rstn = 1'b1;
        e = {3'd0, 2'b00, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL reset_mid_ring got=%b exp=%b", obs(), e); end
        cyc();
        e = {3'd1, 2'b00, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL post_reset_arm got=%b exp=%b", obs(), e); end
        io.ALM_MIN = 6'd41;
        do_tick(5'd7, 6'd41, 6'd0);
        cyc(); cyc();
        e = {3'd2, 2'b11, 2'd2};
        checks++;
        if (obs() !== e) begin failures++; $display("FAIL held_stop_no_edge got=%b exp=%b", obs(), e); end
        io.KEY_STOP = 1'b0;
        io.KEY_PRESS = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ring_timeout();
        test_snooze();
        test_stop_priority();
        test_beep();
        test_disarm();
        test_reset_mid_ring();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
